sd_resp_receiver: RTL
=====================

Name: sd_resp_receiver

Overview:
- Host-side receiver for SD card responses on the CMD line.
- Captures 48-bit (R1/R3/R6/R7) and 136-bit (R2) responses, checks framing, index and CRC7.
- Writes validated fields into the SD register bank (CID/CSD/OCR/RCA) through one-cycle load-enable pulses.
- Sits between the CMD line sampler and the register bank; started by the command sequencer after it finishes sending a command.

Parameters:
- TIMEOUT, 64, number of bit_en ticks to wait for a start bit before flagging a timeout (NCR limit).
- TO_W, 7, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- bit_en  in  1  one-clk strobe marking the SD-clock sample point; cmd_in is only sampled when bit_en=1.
- cmd_in  in  1  synchronised CMD line level.
- start  in  1  one-clk pulse: arm the receiver for one response.
- resp_type  in  2  0=none, 1=48-bit with CRC and index check (R1/R6/R7), 2=136-bit R2, 3=48-bit without CRC or index check (R3).
- exp_index  in  6  expected command index, used for resp_type 1 only.
- load_sel  in  3  destination on success: 0=none, 1=CID, 2=CSD, 3=OCR, 4=RCA; 5–7 behave as 0.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-clk pulse when reception ends (success or error).
- timeout_err, crc_err, frame_err, index_err  out  1 each  status flags, valid with done, held until the next accepted start.
- resp_index  out  6  received index field.
- resp_arg  out  32  received 32-bit argument (48-bit types).
- long_data  out  128  R2 payload: bits [127:1] as received, bit 0 forced to 1.
- cid_en, csd_en, ocr_en, rca_en  out  1 each  one-clk load pulses to the register bank.
- ocr_data  out  32  equals resp_arg.
- rca_data  out  16  equals resp_arg[31:16].

Behaviour:
- Reset (reset=0 at a clk edge): state IDLE. All outputs 0 except long_data bit 0, which is 1. Counters cleared. Reset mid-reception aborts with no done and no enable pulses.
- States: IDLE, WAIT_START, RECV, CHECK.
- IDLE:
  - start=1 with resp_type!=0: latch resp_type, exp_index and load_sel; clear all flags; busy=1; go to WAIT_START.
  - start=1 with resp_type=0: single-cycle done pulse, no flags set, busy stays 0.
  - start while busy=1 is ignored.
- WAIT_START:
  - On each bit_en, cmd_in=0 means the start bit is seen: go to RECV with bit count 1.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT, set timeout_err, pulse done, clear busy, return to IDLE.
  - A start bit on the same tick as the terminal count wins.
- RECV:
  - Shift cmd_in MSB-first on each bit_en.
  - Total bits including the start bit: 48 for types 1/3, 136 for type 2.
  - After the last bit is sampled, go to CHECK on the next clk.
- CHECK (exactly one clk):
  - frame_err if the transmission bit (bit 46 / bit 134) is not 0, or the end bit is not 1.
  - Type 1:
    - CRC7 (x^7+x^3+1, init 0) is computed over bits [47:8]; crc_err if it does not match bits [7:1].
    - index_err if bits [45:40] != exp_index.
  - Type 2:
    - frame_err also set if bits [133:128] != 6'b111111.
    - CRC7 is computed over payload [127:8] and compared against payload [7:1].
  - Type 3: no CRC or index check.
  - Update resp_index, resp_arg and long_data every time, even on error.
  - done=1 and busy=0 in this clk; return to IDLE.
  - If no flag is set, pulse exactly one enable selected by load_sel in the same clk as done.
  - With any flag set, all enables stay 0.
- bit_en asserted on consecutive clks is legal; bit_en is ignored in IDLE and CHECK.
- CRC is computed serially during RECV (one shift per bit_en); no extra latency.

Test Plan:
- R7 to CMD8, type 1, exp_index=8, load_sel=0, CMD bits 0x08_000001AA_13 → done; all flags 0; resp_index=8; resp_arg=0x000001AA; no enables.
- Same frame with arg bit 0 flipped (0x08_000001AB_13) → crc_err=1, all enables 0. Frame with exp_index=9 → index_err=1 only.
- R3, type 3, load_sel=3, frame 0x3F_80FF8000_FF → no flags; ocr_en pulses once; ocr_data=0x80FF8000.
- R2 carrying a CID with a valid internal CRC7, load_sel=1 → cid_en pulses once; long_data matches the CID with bit 0=1. Corrupting one payload bit gives crc_err and no cid_en.
- CMD held high after start with TIMEOUT=64 → timeout_err and done exactly on the 64th bit_en. Start bit on the 64th tick instead → normal reception.
- Reset asserted mid-RECV → busy=0 next clk, no done, no enables. A new start afterwards receives correctly. R1 with end bit 0 → frame_err=1.

Source files
------------

// File: rtl/sd_resp_receiver.sv
// rtl/sd_resp_receiver.sv - SD CMD-line response receiver with framing, index and CRC7 checks

module sd_crc7_step (
    input  logic [6:0] crc,
    input  logic       din,
    output logic [6:0] crc_next
);
    logic fb;

    assign fb       = din ^ crc[6];
    assign crc_next = {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
endmodule

module sd_resp_receiver #(
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         bit_en,
    input  logic         cmd_in,
    input  logic         start,
    input  logic [1:0]   resp_type,
    input  logic [5:0]   exp_index,
    input  logic [2:0]   load_sel,
    output logic         busy,
    output logic         done,
    output logic         timeout_err,
    output logic         crc_err,
    output logic         frame_err,
    output logic         index_err,
    output logic [5:0]   resp_index,
    output logic [31:0]  resp_arg,
    output logic [127:0] long_data,
    output logic         cid_en,
    output logic         csd_en,
    output logic         ocr_en,
    output logic         rca_en,
    output logic [31:0]  ocr_data,
    output logic [15:0]  rca_data
);
    typedef enum logic [1:0] {IDLE, WAIT_START, RECV, CHECK} state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t          state, state_next;
    logic [1:0]      type_q;
    logic [5:0]      idx_q;
    logic [2:0]      sel_q;
    logic [TO_W-1:0] to_cnt;
    logic [7:0]      bit_cnt;
    logic [134:0]    shreg;
    logic [6:0]      crc, crc_step;
    logic [7:0]      total_bits;
    logic            is_long, crc_take;
    logic            start_seen, to_hit, last_bit;
    logic            chk_frame, chk_crc, chk_index, chk_bad;

    assign is_long    = (type_q == 2'd2);
    assign total_bits = is_long ? 8'd136 : 8'd48;

    // bit_cnt counts bits already taken; the CRC window ends 8 bits before the
    // end and, for R2, starts after the start/transmission/reserved-index byte
    assign crc_take = (bit_cnt <= total_bits - 8'd9) && (!is_long || bit_cnt >= 8'd8);

    assign start_seen = (state == WAIT_START) && bit_en && !cmd_in;
    assign to_hit     = (state == WAIT_START) && bit_en && cmd_in && (to_cnt == TO_LAST);
    assign last_bit   = (state == RECV) && bit_en && (bit_cnt == total_bits - 8'd1);

    sd_crc7_step u_crc (
        .crc      (crc),
        .din      (cmd_in),
        .crc_next (crc_step)
    );

    always_comb begin
        chk_frame = 1'b0;
        chk_crc   = 1'b0;
        chk_index = 1'b0;
        if (is_long) begin
            chk_frame = shreg[134] | ~shreg[0] | (shreg[133:128] != 6'h3f);
            chk_crc   = (crc != shreg[7:1]);
        end else begin
            chk_frame = shreg[46] | ~shreg[0];
            if (type_q == 2'd1) begin
                chk_crc   = (crc != shreg[7:1]);
                chk_index = (shreg[45:40] != idx_q);
            end
        end
        chk_bad = chk_frame | chk_crc | chk_index;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (start && resp_type != 2'd0) state_next = WAIT_START;
            WAIT_START: if (start_seen) state_next = RECV;
                        else if (to_hit) state_next = IDLE;
            RECV:       if (last_bit) state_next = CHECK;
            CHECK:      state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            type_q      <= 2'd0;
            idx_q       <= 6'd0;
            sel_q       <= 3'd0;
            to_cnt      <= '0;
            bit_cnt     <= 8'd0;
            shreg       <= '0;
            crc         <= 7'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            crc_err     <= 1'b0;
            frame_err   <= 1'b0;
            index_err   <= 1'b0;
            resp_index  <= 6'd0;
            resp_arg    <= 32'd0;
            long_data   <= 128'd1;
            cid_en      <= 1'b0;
            csd_en      <= 1'b0;
            ocr_en      <= 1'b0;
            rca_en      <= 1'b0;
        end else begin
            done   <= 1'b0;
            cid_en <= 1'b0;
            csd_en <= 1'b0;
            ocr_en <= 1'b0;
            rca_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        timeout_err <= 1'b0;
                        crc_err     <= 1'b0;
                        frame_err   <= 1'b0;
                        index_err   <= 1'b0;
                        if (resp_type != 2'd0) begin
                            type_q <= resp_type;
                            idx_q  <= exp_index;
                            sel_q  <= load_sel;
                            to_cnt <= '0;
                            busy   <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                WAIT_START: begin
                    if (bit_en) begin
                        if (!cmd_in) begin
                            shreg   <= '0;
                            bit_cnt <= 8'd1;
                            crc     <= 7'd0;
                        end else if (to_cnt == TO_LAST) begin
                            timeout_err <= 1'b1;
                            done        <= 1'b1;
                            busy        <= 1'b0;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (bit_en) begin
                        shreg   <= {shreg[133:0], cmd_in};
                        bit_cnt <= bit_cnt + 8'd1;
                        if (crc_take) crc <= crc_step;
                    end
                end
                CHECK: begin
                    frame_err  <= chk_frame;
                    crc_err    <= chk_crc;
                    index_err  <= chk_index;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    resp_index <= is_long ? shreg[133:128] : shreg[45:40];
                    resp_arg   <= shreg[39:8];
                    long_data  <= {shreg[127:1], 1'b1};
                    if (!chk_bad) begin
                        case (sel_q)
                            3'd1:    cid_en <= 1'b1;
                            3'd2:    csd_en <= 1'b1;
                            3'd3:    ocr_en <= 1'b1;
                            3'd4:    rca_en <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    assign ocr_data = resp_arg;
    assign rca_data = resp_arg[31:16];
endmodule
